apb_bus_master: RTL and testbench
=================================

Name: apb_bus_master

Overview:
- Sequencing controller for the core's peripheral bus path.
- When the control unit flags a load/store to peripheral space (`transfer`), the block runs an APB-style SETUP/ACCESS handshake and decodes the slave select.
- It waits on `READY` with a bounded timeout, then returns a one-cycle `access_done` plus latched read data.
- The datapath uses `access_done` to release its PC stall and to write the peripheral read data to the register file.

Parameters:
- ADDR_W, 32, width of bus address.
- DATA_W, 32, width of read/write data.
- NUM_SLAVES, 4, number of select lines (power of two, >= 2).
- SEL_LSB, 12, lowest address bit of the slave-index field.
- TIMEOUT, 15, maximum ACCESS cycles with READY low before abort (1..255).

Ports:
- CLK  input  1  system clock, all state on rising edge.
- RESET  input  1  asynchronous active-high reset.
- transfer  input  1  peripheral access request from control unit; sampled only in IDLE.
- WRITE_req  input  1  1 = store, 0 = load; captured with transfer.
- ADDR_in  input  ADDR_W  access address (ALU result); captured with transfer.
- WDATA_in  input  DATA_W  store data; captured with transfer.
- READY  input  1  slave ready (PREADY).
- SLVERR  input  1  slave error, valid when READY=1 in ACCESS.
- RDATA  input  DATA_W  slave read data, valid when READY=1 in ACCESS.
- PADDR  output  ADDR_W  bus address.
- PSEL  output  NUM_SLAVES  one-hot slave select.
- ENABLE  output  1  access phase strobe (PENABLE).
- WRITE  output  1  bus direction (PWRITE).
- WDATA  output  DATA_W  bus write data; 0 unless a write is in SETUP/ACCESS.
- RDATA_q  output  DATA_W  latched read data.
- access_done  output  1  one-cycle completion pulse.
- bus_error  output  1  one-cycle error pulse, coincident with access_done.

Behaviour:
- Reset (asynchronous, any time including mid-access):
  - State goes to IDLE.
  - All outputs are 0: PADDR, PSEL, ENABLE, WRITE, WDATA, RDATA_q, access_done, bus_error.
  - The wait counter clears.
- States: IDLE, SETUP, ACCESS, DONE. All outputs are registered or decoded from registered state; there is no combinational path from input to output.
- IDLE:
  - PSEL=0 and ENABLE=0.
  - If transfer=1, capture ADDR_in, WDATA_in and WRITE_req.
  - Decode idx = ADDR_in[SEL_LSB +: log2(NUM_SLAVES)].
  - If ADDR_in bits above the index field are nonzero, it is a decode error: go to DONE with err flag set, no bus cycle, PSEL stays 0.
  - Otherwise go to SETUP.
- SETUP (exactly 1 cycle):
  - PSEL[idx]=1, ENABLE=0.
  - PADDR and WRITE driven from captured values; WDATA = captured data if write, else 0.
  - Next state is ACCESS.
- ACCESS:
  - PSEL, PADDR, WRITE and WDATA held stable; ENABLE=1.
  - READY=1: for a load, RDATA_q <= RDATA. err flag <= SLVERR; if SLVERR=1 on a load, RDATA_q <= 0. Go to DONE.
  - READY=0: wait counter increments. When the counter reaches TIMEOUT with READY still 0, abort: set err flag, RDATA_q <= 0, go to DONE.
  - READY takes priority over timeout in the same cycle.
- DONE (exactly 1 cycle):
  - access_done=1 and bus_error=err flag.
  - PSEL=0, ENABLE=0, WDATA=0.
  - Counter cleared; next state is always IDLE.
  - transfer is ignored in DONE; a back-to-back request is accepted in the following IDLE cycle.
- RDATA_q holds its value until the next completed load or reset. Writes do not alter it.
- Zero-wait latency: request sampled in cycle N (IDLE), SETUP N+1, ACCESS N+2, access_done N+3. Minimum request-to-request spacing is 4 cycles.
- Counter width is 8 bits and saturates; it never wraps.
- Changes to ADDR_in, WDATA_in or WRITE_req after capture have no effect until the next IDLE.

Test Plan:
- Zero-wait read:
  - Stimulus: transfer=1, WRITE_req=0, ADDR_in=0x0000_1004; READY=1 in ACCESS with RDATA=0xDEAD_BEEF.
  - Required: PSEL=4'b0010 for 2 cycles; ENABLE=1 only in cycle N+2; access_done at N+3; RDATA_q=0xDEAD_BEEF; bus_error=0.
- Write with 3 wait states:
  - Stimulus: ADDR_in=0x0000_3010, WDATA_in=0x1234_5678; READY low for 3 ACCESS cycles.
  - Required: PSEL=4'b1000; WDATA=0x1234_5678 stable SETUP through ACCESS; access_done at N+6; RDATA_q unchanged.
- Timeout:
  - Stimulus: READY held 0 through ACCESS.
  - Required: after 15 ACCESS cycles the FSM enters DONE; access_done=1 with bus_error=1; RDATA_q=0.
- Decode error:
  - Stimulus: ADDR_in=0x0001_0000.
  - Required: PSEL never asserted; access_done and bus_error both 1 at N+1.
- Slave error:
  - Stimulus: read with READY=1 and SLVERR=1 in ACCESS.
  - Required: bus_error=1 in DONE; RDATA_q=0.
- Reset mid-access and back-to-back requests:
  - Stimulus: assert RESET during ACCESS, then release.
  - Required: all outputs 0 immediately (asynchronous); IDLE on release; no access_done pulse.
  - Stimulus: hold transfer=1 continuously.
  - Required: access_done pulses every 4 cycles with READY=1.

Source files
------------

// File: rtl/apb_bus_master_if.sv
// Peripheral bus bundle between the core's control/datapath side and the
// APB-style slaves. The master modport is what apb_bus_master sees.
interface apb_bus_master_if #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4
);
    // Request side (control unit / datapath)
    logic                  transfer;
    logic                  WRITE_req;
    logic [ADDR_W-1:0]     ADDR_in;
    logic [DATA_W-1:0]     WDATA_in;
    logic [DATA_W-1:0]     RDATA_q;
    logic                  access_done;
    logic                  bus_error;

    // Bus side (slaves)
    logic                  READY;
    logic                  SLVERR;
    logic [DATA_W-1:0]     RDATA;
    logic [ADDR_W-1:0]     PADDR;
    logic [NUM_SLAVES-1:0] PSEL;
    logic                  ENABLE;
    logic                  WRITE;
    logic [DATA_W-1:0]     WDATA;

    modport master (
        input  transfer, WRITE_req, ADDR_in, WDATA_in, READY, SLVERR, RDATA,
        output PADDR, PSEL, ENABLE, WRITE, WDATA, RDATA_q, access_done, bus_error
    );

    modport slave (
        output transfer, WRITE_req, ADDR_in, WDATA_in, READY, SLVERR, RDATA,
        input  PADDR, PSEL, ENABLE, WRITE, WDATA, RDATA_q, access_done, bus_error
    );
endinterface

// File: rtl/apb_bus_master.sv
// APB-style peripheral bus sequencer. Captures a load/store request in IDLE,
// decodes the slave select from an address field, runs SETUP/ACCESS with a
// bounded wait on READY and finishes with a one-cycle DONE pulse.
// Every output is decoded from registered state only.
module apb_bus_master #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4,
    parameter int SEL_LSB    = 12,
    parameter int TIMEOUT    = 15
) (
    input  logic                  CLK,
    input  logic                  RESET,
    apb_bus_master_if.master      bus
);
    localparam int              IDX_W    = $clog2(NUM_SLAVES);
    localparam int              HI_LSB   = SEL_LSB + IDX_W;
    localparam logic [7:0]      TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                write_q, write_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                err_q, err_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                upper_nz;
    logic                in_bus;
    logic [NUM_SLAVES-1:0] psel_dec;

    // Any set bit above the slave-index field means no slave owns the address
    assign upper_nz = |(bus.ADDR_in >> HI_LSB);

    // State and captured-request registers, cleared asynchronously
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic: request capture, wait counting, completion status
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        idx_d   = idx_q;
        err_d   = err_q;
        cnt_d   = '0;
        rdata_d = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (bus.transfer) begin
                    addr_d  = bus.ADDR_in;
                    wdata_d = bus.WDATA_in;
                    write_d = bus.WRITE_req;
                    idx_d   = bus.ADDR_in[SEL_LSB +: IDX_W];
                    if (upper_nz) begin
                        // Decode error: skip the bus cycle entirely
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                // READY wins over the timeout when both happen together
                if (bus.READY) begin
                    err_d = bus.SLVERR;
                    if (!write_q) begin
                        rdata_d = bus.SLVERR ? '0 : bus.RDATA;
                    end
                    state_d = S_DONE;
                end else if (cnt_q >= TMO_LAST) begin
                    // This is the TIMEOUT-th cycle with READY low: give up
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus phase flag shared by the select, direction and write-data decodes
    always_comb begin
        in_bus = (state_q == S_SETUP) || (state_q == S_ACCESS);
    end

    // One-hot slave select from the registered index
    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_psel
            assign psel_dec[gi] = in_bus && (idx_q == IDX_W'(gi));
        end
    endgenerate

    assign bus.PADDR       = addr_q;
    assign bus.PSEL        = psel_dec;
    assign bus.ENABLE      = (state_q == S_ACCESS);
    assign bus.WRITE       = in_bus && write_q;
    assign bus.WDATA       = (in_bus && write_q) ? wdata_q : '0;
    assign bus.RDATA_q     = rdata_q;
    assign bus.access_done = (state_q == S_DONE);
    assign bus.bus_error   = (state_q == S_DONE) && err_q;
endmodule

// File: tb/tb_apb_bus_master.sv
// Directed bench for apb_bus_master: zero-wait read, wait-state write,
// timeout, decode error, slave error, reset mid-access and back-to-back.
module tb_apb_bus_master;
    logic CLK;
    logic RESET;
    int   checks;
    int   failures;

    apb_bus_master_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(4)) bus_if ();

    apb_bus_master #(
        .ADDR_W(32), .DATA_W(32), .NUM_SLAVES(4), .SEL_LSB(12), .TIMEOUT(15)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus_if.master)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Zero-wait read; caller is in an IDLE cycle
    task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] rd,
                           input logic slverr, input logic [3:0] exp_psel,
                           input logic [31:0] exp_rq, input logic exp_err);
        bus_if.transfer  = 1'b1;
        bus_if.WRITE_req = 1'b0;
        bus_if.ADDR_in   = addr;
        step();                                    // SETUP
        bus_if.transfer = 1'b0;
        check({tag, "_setup_psel"}, bus_if.PSEL, exp_psel);
        check({tag, "_setup_en"}, bus_if.ENABLE, 1'b0);
        step();                                    // ACCESS
        check({tag, "_access_psel"}, bus_if.PSEL, exp_psel);
        check({tag, "_access_en"}, bus_if.ENABLE, 1'b1);
        bus_if.READY  = 1'b1;
        bus_if.SLVERR = slverr;
        bus_if.RDATA  = rd;
        step();                                    // DONE
        bus_if.READY  = 1'b0;
        bus_if.SLVERR = 1'b0;
        check({tag, "_done"}, bus_if.access_done, 1'b1);
        check({tag, "_err"}, bus_if.bus_error, exp_err);
        check({tag, "_done_psel"}, bus_if.PSEL, 4'b0000);
        check({tag, "_rdata_q"}, bus_if.RDATA_q, exp_rq);
        step();                                    // back to IDLE
        check({tag, "_idle_done"}, bus_if.access_done, 1'b0);
        $display("read %s addr=%08h rdata_q=%08h err=%0b", tag, addr, bus_if.RDATA_q, exp_err);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        RESET = 1'b1;
        bus_if.transfer  = 1'b0;
        bus_if.WRITE_req = 1'b0;
        bus_if.ADDR_in   = '0;
        bus_if.WDATA_in  = '0;
        bus_if.READY     = 1'b0;
        bus_if.SLVERR    = 1'b0;
        bus_if.RDATA     = '0;
        step();
        step();

        // Reset state
        check("rst_paddr", bus_if.PADDR, 32'h0);
        check("rst_psel", bus_if.PSEL, 4'b0000);
        check("rst_enable", bus_if.ENABLE, 1'b0);
        check("rst_write", bus_if.WRITE, 1'b0);
        check("rst_wdata", bus_if.WDATA, 32'h0);
        check("rst_rdata_q", bus_if.RDATA_q, 32'h0);
        check("rst_done", bus_if.access_done, 1'b0);
        check("rst_err", bus_if.bus_error, 1'b0);
        $display("reset released");
        RESET = 1'b0;
        step();

        // Zero-wait read to slave 1
        check("zw_paddr_pre", bus_if.PSEL, 4'b0000);
        do_read("zw", 32'h0000_1004, 32'hDEAD_BEEF, 1'b0, 4'b0010, 32'hDEAD_BEEF, 1'b0);

        // Write to slave 3 with 3 wait states; inputs change after capture
        bus_if.transfer  = 1'b1;
        bus_if.WRITE_req = 1'b1;
        bus_if.ADDR_in   = 32'h0000_3010;
        bus_if.WDATA_in  = 32'h1234_5678;
        step();                                    // N+1 SETUP
        bus_if.transfer  = 1'b0;
        bus_if.WRITE_req = 1'b0;
        bus_if.ADDR_in   = 32'h0000_0000;
        bus_if.WDATA_in  = 32'hFFFF_FFFF;
        check("wr_setup_psel", bus_if.PSEL, 4'b1000);
        check("wr_setup_wdata", bus_if.WDATA, 32'h1234_5678);
        check("wr_setup_write", bus_if.WRITE, 1'b1);
        check("wr_setup_paddr", bus_if.PADDR, 32'h0000_3010);
        for (int i = 0; i < 3; i++) begin
            step();                                // N+2..N+4 ACCESS, READY low
            check("wr_wait_en", bus_if.ENABLE, 1'b1);
            check("wr_wait_wdata", bus_if.WDATA, 32'h1234_5678);
            check("wr_wait_psel", bus_if.PSEL, 4'b1000);
            check("wr_wait_done", bus_if.access_done, 1'b0);
        end
        step();                                    // N+5 ACCESS, READY high
        check("wr_last_en", bus_if.ENABLE, 1'b1);
        bus_if.READY = 1'b1;
        step();                                    // N+6 DONE
        bus_if.READY = 1'b0;
        check("wr_done", bus_if.access_done, 1'b1);
        check("wr_err", bus_if.bus_error, 1'b0);
        check("wr_done_wdata", bus_if.WDATA, 32'h0);
        check("wr_rdata_q_kept", bus_if.RDATA_q, 32'hDEAD_BEEF);
        $display("write addr=00003010 wdata=12345678 done at N+6");
        step();

        // Timeout: read to slave 2, READY never rises
        bus_if.transfer = 1'b1;
        bus_if.ADDR_in  = 32'h0000_2000;
        step();                                    // SETUP
        bus_if.transfer = 1'b0;
        check("to_setup_psel", bus_if.PSEL, 4'b0100);
        for (int i = 0; i < 15; i++) begin
            step();                                // 15 ACCESS cycles
            check("to_wait_en", bus_if.ENABLE, 1'b1);
            check("to_wait_done", bus_if.access_done, 1'b0);
        end
        step();                                    // DONE
        check("to_done", bus_if.access_done, 1'b1);
        check("to_err", bus_if.bus_error, 1'b1);
        check("to_rdata_q", bus_if.RDATA_q, 32'h0);
        $display("timeout after 15 access cycles err=%0b", bus_if.bus_error);
        step();

        // Decode error: address above the index field
        bus_if.transfer = 1'b1;
        bus_if.ADDR_in  = 32'h0001_0000;
        step();                                    // N+1 DONE
        bus_if.transfer = 1'b0;
        check("de_done", bus_if.access_done, 1'b1);
        check("de_err", bus_if.bus_error, 1'b1);
        check("de_psel", bus_if.PSEL, 4'b0000);
        check("de_enable", bus_if.ENABLE, 1'b0);
        step();
        check("de_idle_done", bus_if.access_done, 1'b0);
        check("de_idle_psel", bus_if.PSEL, 4'b0000);
        $display("decode error addr=00010000");

        // Good read then slave-error read
        do_read("ok0", 32'h0000_0008, 32'hA5A5_5A5A, 1'b0, 4'b0001, 32'hA5A5_5A5A, 1'b0);
        do_read("slverr", 32'h0000_1000, 32'hFFFF_FFFF, 1'b1, 4'b0010, 32'h0, 1'b1);
        do_read("ok1", 32'h0000_3000, 32'h0BAD_F00D, 1'b0, 4'b1000, 32'h0BAD_F00D, 1'b0);

        // Reset asserted during ACCESS
        bus_if.transfer = 1'b1;
        bus_if.ADDR_in  = 32'h0000_1000;
        step();
        bus_if.transfer = 1'b0;
        step();                                    // ACCESS
        check("mr_access_en", bus_if.ENABLE, 1'b1);
        #2;
        RESET = 1'b1;
        #1;
        check("mr_psel", bus_if.PSEL, 4'b0000);
        check("mr_enable", bus_if.ENABLE, 1'b0);
        check("mr_paddr", bus_if.PADDR, 32'h0);
        check("mr_rdata_q", bus_if.RDATA_q, 32'h0);
        check("mr_done", bus_if.access_done, 1'b0);
        step();
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("mr_post_done", bus_if.access_done, 1'b0);
            check("mr_post_psel", bus_if.PSEL, 4'b0000);
        end
        $display("reset mid-access cleared outputs");

        // Back-to-back: transfer held high, READY high
        bus_if.transfer = 1'b1;
        bus_if.ADDR_in  = 32'h0000_0000;
        bus_if.READY    = 1'b1;
        bus_if.RDATA    = 32'h1111_2222;
        for (int i = 1; i <= 12; i++) begin
            step();
            check("b2b_done", bus_if.access_done, ((i % 4) == 3) ? 1'b1 : 1'b0);
        end
        bus_if.transfer = 1'b0;
        bus_if.READY    = 1'b0;
        check("b2b_rdata_q", bus_if.RDATA_q, 32'h1111_2222);
        $display("back-to-back access_done every 4 cycles");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
